// File: rtl/alu_multicycle.sv
// Non-pipelined ALU with valid/ready handshakes, an iterative shift-add multiplier
// and registered Z/N/V status flags. One operation in flight at a time.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic [1:0]       dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_n;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 z_q, z_d, n_q, n_d, v_q, v_d;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_v;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE->IDLE never accepts.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out         = out_q;
  assign Z           = z_q;
  assign N           = n_q;
  assign V           = v_q;
  assign dbg_state_o = state_q;

  // Single-cycle ops evaluate straight from the operands presented at accept.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALUop)
      3'b000: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (alu_res[WIDTH-1] != Ain[WIDTH-1]);
      end
      3'b001: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (alu_res[WIDTH-1] != Ain[WIDTH-1]);
      end
      3'b010:  alu_res = Ain & Bin;
      3'b011:  alu_res = ~Bin;
      3'b100:  alu_res = Ain | Bin;
      3'b101:  alu_res = Ain ^ Bin;
      3'b110:  alu_res = Ain << Bin[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    acc_n   = b_q[0] ? (acc_q + a_q) : acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (ALUop == 3'b111) begin
            a_d     = {{WIDTH{1'b0}}, Ain};
            b_d     = Bin;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            out_d   = alu_res;
            z_d     = (alu_res == '0);
            n_d     = alu_res[WIDTH-1];
            v_d     = alu_v;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        acc_d = acc_n;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // The last iteration's sum goes straight to the result so DONE lands WIDTH edges after accept.
        if (cnt_q == CNT_LAST) begin
          out_d   = acc_n[WIDTH-1:0];
          z_d     = (acc_n[WIDTH-1:0] == '0);
          n_d     = acc_n[WIDTH-1];
          v_d     = |acc_n[2*WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

endmodule
